// File: rtl/noc_credit_injector.sv
// Credit-based NoC flit injector: accepts packets from a source, tags head/tail,
// and emits them on a channel subject to per-VC downstream credits.
module noc_credit_injector #(
  parameter int unsigned NUM_VCS         = 2,
  parameter int unsigned FLIT_DATA_WIDTH = 64,
  parameter int unsigned CREDITS_PER_VC  = 8,
  parameter int unsigned MAX_PKT_FLITS   = 4,
  localparam int unsigned VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       src_valid,
  output logic                       src_ready,
  input  logic [VW-1:0]              src_vc,
  input  logic                       src_last,
  input  logic [FLIT_DATA_WIDTH-1:0] src_data,
  output logic                       chan_valid,
  output logic                       chan_head,
  output logic                       chan_tail,
  output logic [VW-1:0]              chan_vc,
  output logic [FLIT_DATA_WIDTH-1:0] chan_data,
  input  logic                       credit_valid,
  input  logic [VW-1:0]              credit_vc,
  output logic                       busy,
  output logic                       error
);

  localparam int unsigned CW = $clog2(CREDITS_PER_VC + 1);
  localparam int unsigned PW = $clog2(MAX_PKT_FLITS + 1);

  typedef enum logic {IDLE, BODY} state_e;

  state_e                     state_q, state_d;
  logic [VW-1:0]              vc_q, vc_d;
  logic [PW-1:0]              cnt_q, cnt_d;
  logic [CW-1:0]              credit_q [NUM_VCS];
  logic [CW-1:0]              credit_d [NUM_VCS];
  logic                       error_q, error_d;
  logic                       chan_valid_q, chan_head_q, chan_tail_q;
  logic [VW-1:0]              chan_vc_q;
  logic [FLIT_DATA_WIDTH-1:0] chan_data_q;

  logic [VW-1:0] eff_vc;
  logic          eff_ok;
  logic          accept;
  logic [PW-1:0] flit_no;
  logic          at_max;
  logic          tail;
  logic          forced;

  // The head flit picks the VC; body flits stay on the VC latched at the head.
  always_comb begin
    eff_vc    = (state_q == IDLE) ? src_vc : vc_q;
    eff_ok    = 32'(eff_vc) < NUM_VCS;
    src_ready = eff_ok && (credit_q[eff_vc] != '0);
    accept    = src_valid & src_ready;
    flit_no   = (state_q == IDLE) ? PW'(1) : cnt_q + PW'(1);
    at_max    = (flit_no == PW'(MAX_PKT_FLITS));
    tail      = src_last | at_max;
    forced    = accept & ~src_last & at_max;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = tail ? IDLE : BODY;
  end

  always_comb begin
    busy = (state_q == BODY);
  end

  always_comb begin
    vc_d  = vc_q;
    cnt_d = cnt_q;
    if (accept) begin
      if (state_q == IDLE) vc_d = src_vc;
      cnt_d = tail ? '0 : flit_no;
    end
  end

  // A send and a return on the same VC cancel, so a full counter only
  // overflows when the return arrives with no send on that VC.
  always_comb begin
    error_d = error_q | forced;
    if (credit_valid && !(32'(credit_vc) < NUM_VCS)) error_d = 1'b1;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      credit_d[v] = credit_q[v];
      if (accept && (32'(eff_vc) == v) && !(credit_valid && (32'(credit_vc) == v))) begin
        credit_d[v] = credit_q[v] - CW'(1);
      end else if (credit_valid && (32'(credit_vc) == v) && !(accept && (32'(eff_vc) == v))) begin
        if (credit_q[v] == CW'(CREDITS_PER_VC)) error_d = 1'b1;
        else                                    credit_d[v] = credit_q[v] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vc_q    <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
      for (int unsigned v = 0; v < NUM_VCS; v++) credit_q[v] <= CW'(CREDITS_PER_VC);
    end else begin
      vc_q    <= vc_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
      for (int unsigned v = 0; v < NUM_VCS; v++) credit_q[v] <= credit_d[v];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chan_valid_q <= 1'b0;
      chan_head_q  <= 1'b0;
      chan_tail_q  <= 1'b0;
      chan_vc_q    <= '0;
      chan_data_q  <= '0;
    end else begin
      chan_valid_q <= accept;
      if (accept) begin
        chan_head_q <= (state_q == IDLE);
        chan_tail_q <= tail;
        chan_vc_q   <= eff_vc;
        chan_data_q <= src_data;
      end
    end
  end

  assign chan_valid = chan_valid_q;
  assign chan_head  = chan_head_q;
  assign chan_tail  = chan_tail_q;
  assign chan_vc    = chan_vc_q;
  assign chan_data  = chan_data_q;
  assign error      = error_q;

endmodule

// File: tb/tb_noc_credit_injector.sv
// Self-checking bench for noc_credit_injector: directed vector table, corner-case
// sequences, and randomized traffic against a packet/credit reference model.
module tb_noc_credit_injector;

  localparam int NV   = 2;
  localparam int CRED = 8;
  localparam int MAXF = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        src_valid = 1'b0, src_last = 1'b0, src_vc = 1'b0;
  logic [63:0] src_data = '0;
  logic        src_ready;
  logic        chan_valid, chan_head, chan_tail, chan_vc;
  logic [63:0] chan_data;
  logic        credit_valid = 1'b0, credit_vc = 1'b0;
  logic        busy, error;

  int n_cmp  = 0;
  int n_fail = 0;

  noc_credit_injector #(
    .NUM_VCS(NV), .FLIT_DATA_WIDTH(64), .CREDITS_PER_VC(CRED), .MAX_PKT_FLITS(MAXF)
  ) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_ready(src_ready), .src_vc(src_vc),
    .src_last(src_last), .src_data(src_data),
    .chan_valid(chan_valid), .chan_head(chan_head), .chan_tail(chan_tail),
    .chan_vc(chan_vc), .chan_data(chan_data),
    .credit_valid(credit_valid), .credit_vc(credit_vc),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic vc; logic l; logic [63:0] d; logic cv; logic cvc;
    logic e_rdy; logic e_cval; logic e_head; logic e_tail; logic e_vc;
    logic [63:0] e_data; logic e_busy; logic e_err;
  } vec_t;
  vec_t tbl [6];

  // Reference model state
  int          mc [NV];
  bit          in_pkt;
  logic        pkt_vc;
  int          pkt_len;
  bit          merr;
  logic        mv, mh, mt, mvc;
  logic [63:0] mdata;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkd(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic vc, input logic l, input logic [63:0] d,
                       input logic cv, input logic cvc);
    src_valid = v; src_vc = vc; src_last = l; src_data = d;
    credit_valid = cv; credit_vc = cvc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) mc[v] = CRED;
    in_pkt = 0; pkt_vc = 1'b0; pkt_len = 0; merr = 0;
    mv = 1'b0; mh = 1'b0; mt = 1'b0; mvc = 1'b0; mdata = '0;
  endtask

  // Reset asserted mid-cycle; outputs are checked before any clock edge.
  task automatic apply_reset();
    src_valid = 1'b0; src_last = 1'b0; src_vc = 1'b0; src_data = '0;
    credit_valid = 1'b0; credit_vc = 1'b0;
    reset = 1'b1;
    #2;
    chk1("rst_chan_valid", chan_valid, 1'b0);
    chk1("rst_chan_head", chan_head, 1'b0);
    chk1("rst_chan_tail", chan_tail, 1'b0);
    chk1("rst_chan_vc", chan_vc, 1'b0);
    chkd("rst_chan_data", chan_data, 64'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_error", error, 1'b0);
    chk1("rst_ready", src_ready, 1'b1);
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic        rv, rvc, rl, rcv, rcvc, ev, acc;
    logic [63:0] rd;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 64'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'hA1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 64'hB1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'hB1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 64'hB2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'hB2, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 64'hB3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'hB3, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 64'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'hB3, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 64'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'hB3, 1'b0, 1'b1};

    #1;
    apply_reset();

    // Single flit on VC1, 3-flit packet on VC0 with src_vc toggled, credit overflow
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].v, tbl[i].vc, tbl[i].l, tbl[i].d, tbl[i].cv, tbl[i].cvc);
      chk1($sformatf("tbl%0d_ready", i), src_ready, tbl[i].e_rdy);
      tick();
      chk1($sformatf("tbl%0d_chan_valid", i), chan_valid, tbl[i].e_cval);
      chk1($sformatf("tbl%0d_head", i), chan_head, tbl[i].e_head);
      chk1($sformatf("tbl%0d_tail", i), chan_tail, tbl[i].e_tail);
      chk1($sformatf("tbl%0d_vc", i), chan_vc, tbl[i].e_vc);
      chkd($sformatf("tbl%0d_data", i), chan_data, tbl[i].e_data);
      chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk1($sformatf("tbl%0d_error", i), error, tbl[i].e_err);
    end

    // Credit exhaustion on VC0, then one return reopens it
    apply_reset();
    for (int i = 0; i < CRED; i++) begin
      drive(1'b1, 1'b0, 1'b1, 64'(i), 1'b0, 1'b0);
      chk1("exh_ready_pre", src_ready, 1'b1);
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, 64'h55, 1'b0, 1'b0);
    chk1("exh_ready_vc0", src_ready, 1'b0);
    tick();
    chk1("exh_no_accept", chan_valid, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    chk1("exh_ready_vc1", src_ready, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk1("exh_ready_same_cycle", src_ready, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk1("exh_ready_after_ret", src_ready, 1'b1);
    // Simultaneous send and return on VC0 keeps the count at 1
    drive(1'b1, 1'b0, 1'b1, 64'h66, 1'b1, 1'b0);
    tick();
    chk1("sim_chan_valid", chan_valid, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 64'h77, 1'b0, 1'b0);
    chk1("sim_ready_kept", src_ready, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk1("sim_ready_drained", src_ready, 1'b0);
    chk1("sim_no_error", error, 1'b0);

    // Overlength packet: 4th flit is forced tail, 5th starts a new packet
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 64'(i), 1'b0, 1'b0);
      tick();
      chk1($sformatf("ol%0d_valid", i), chan_valid, 1'b1);
      chk1($sformatf("ol%0d_head", i), chan_head, (i == 1) || (i == 5));
      chk1($sformatf("ol%0d_tail", i), chan_tail, i == 4);
      chk1($sformatf("ol%0d_error", i), error, i >= 4);
      chk1($sformatf("ol%0d_busy", i), busy, i != 4);
    end

    // Reset in BODY, then the next flit must be a head
    apply_reset();
    drive(1'b1, 1'b1, 1'b0, 64'hC1, 1'b0, 1'b0);
    tick();
    chk1("mid_busy", busy, 1'b1);
    apply_reset();
    drive(1'b1, 1'b0, 1'b1, 64'hC2, 1'b0, 1'b0);
    tick();
    chk1("mid_head", chan_head, 1'b1);
    chk1("mid_tail", chan_tail, 1'b1);
    chk1("mid_vc", chan_vc, 1'b0);

    // Randomized traffic against the reference model
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 299) apply_reset();
      rv   = ($urandom_range(0, 3) != 0);
      rvc  = 1'($urandom_range(0, 1));
      rl   = ($urandom_range(0, 2) == 0);
      rd   = {$urandom(), $urandom()};
      rcvc = 1'($urandom_range(0, 1));
      rcv  = (mc[rcvc] < CRED) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      drive(rv, rvc, rl, rd, rcv, rcvc);
      ev = in_pkt ? pkt_vc : rvc;
      chk1("rnd_ready", src_ready, mc[ev] > 0);
      tick();
      acc = rv && (mc[ev] > 0);
      mv = acc;
      if (acc) begin
        mh = !in_pkt;
        if (!in_pkt) begin
          pkt_vc  = rvc;
          pkt_len = 0;
        end
        pkt_len++;
        mt = rl || (pkt_len == MAXF);
        if (!rl && pkt_len == MAXF) merr = 1;
        in_pkt = !mt;
        mvc    = ev;
        mdata  = rd;
        mc[ev]--;
      end
      if (rcv) mc[rcvc]++;
      for (int v = 0; v < NV; v++) begin
        if (mc[v] > CRED) begin
          mc[v] = CRED;
          merr  = 1;
        end
      end
      chk1("rnd_chan_valid", chan_valid, mv);
      chk1("rnd_head", chan_head, mh);
      chk1("rnd_tail", chan_tail, mt);
      chk1("rnd_vc", chan_vc, mvc);
      chkd("rnd_data", chan_data, mdata);
      chk1("rnd_busy", busy, in_pkt);
      chk1("rnd_error", error, merr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
